// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4-subset arbiter with independent round-robin
// read and write paths. Bursts pass through untouched; the grant is held
// until rlast (read) or the B handshake (write).
// Ports: clk/reset; m_* per-master AXI channels, master 0 in the LSB slice;
// s_* single slave port; rd_busy/wr_busy and rd_gnt/wr_gnt show grant state.
module axi_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int GNT_W       = $clog2(NUM_MASTERS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_MASTERS-1:0]          m_arvalid,
   output logic [NUM_MASTERS-1:0]          m_arready,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_araddr,
   input  logic [NUM_MASTERS*8-1:0]        m_arlen,
   input  logic [NUM_MASTERS*3-1:0]        m_arsize,
   output logic [NUM_MASTERS-1:0]          m_rvalid,
   input  logic [NUM_MASTERS-1:0]          m_rready,
   output logic [NUM_MASTERS*DATA_W-1:0]   m_rdata,
   output logic [NUM_MASTERS*2-1:0]        m_rresp,
   output logic [NUM_MASTERS-1:0]          m_rlast,
   input  logic [NUM_MASTERS-1:0]          m_awvalid,
   output logic [NUM_MASTERS-1:0]          m_awready,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_awaddr,
   input  logic [NUM_MASTERS*8-1:0]        m_awlen,
   input  logic [NUM_MASTERS*3-1:0]        m_awsize,
   input  logic [NUM_MASTERS-1:0]          m_wvalid,
   output logic [NUM_MASTERS-1:0]          m_wready,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
   input  logic [NUM_MASTERS-1:0]          m_wlast,
   output logic [NUM_MASTERS-1:0]          m_bvalid,
   input  logic [NUM_MASTERS-1:0]          m_bready,
   output logic [NUM_MASTERS*2-1:0]        m_bresp,
   output logic                            s_arvalid,
   input  logic                            s_arready,
   output logic [ADDR_W-1:0]               s_araddr,
   output logic [7:0]                      s_arlen,
   output logic [2:0]                      s_arsize,
   input  logic                            s_rvalid,
   output logic                            s_rready,
   input  logic [DATA_W-1:0]               s_rdata,
   input  logic [1:0]                      s_rresp,
   input  logic                            s_rlast,
   output logic                            s_awvalid,
   input  logic                            s_awready,
   output logic [ADDR_W-1:0]               s_awaddr,
   output logic [7:0]                      s_awlen,
   output logic [2:0]                      s_awsize,
   output logic                            s_wvalid,
   input  logic                            s_wready,
   output logic [DATA_W-1:0]               s_wdata,
   output logic [DATA_W/8-1:0]             s_wstrb,
   output logic                            s_wlast,
   input  logic                            s_bvalid,
   output logic                            s_bready,
   input  logic [1:0]                      s_bresp,
   output logic                            rd_busy,
   output logic                            wr_busy,
   output logic [GNT_W-1:0]                rd_gnt,
   output logic [GNT_W-1:0]                wr_gnt
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;

   // First requester at or above ptr, wrapping modulo NUM_MASTERS.
   function automatic logic [GNT_W-1:0] rr_pick(
      input logic [GNT_W-1:0]       ptr,
      input logic [NUM_MASTERS-1:0] req
   );
      logic [GNT_W-1:0] pick;
      logic [GNT_W-1:0] gi;
      logic             found;
      int               idx;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (int'(ptr) + k) % NUM_MASTERS;
         gi  = GNT_W'(idx);
         if (!found && req[gi]) begin
            pick  = gi;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [GNT_W-1:0] wrap_inc(input logic [GNT_W-1:0] g);
      return (int'(g) == NUM_MASTERS - 1) ? '0 : g + GNT_W'(1);
   endfunction

   r_state_t                  r_state, r_next;
   w_state_t                  w_state, w_next;
   logic [GNT_W-1:0]          rd_ptr, rd_gnt_q;
   logic [GNT_W-1:0]          wr_ptr, wr_gnt_q;
   logic [NUM_MASTERS*DATA_W-1:0] hold_q;
   logic                      aw_done, w_done;
   logic                      ar_hs, r_hs, aw_hs, w_last_hs, b_hs;
   logic                      aw_fin, w_fin;

   assign ar_hs     = s_arvalid & s_arready;
   assign r_hs      = s_rvalid & s_rready;
   assign aw_hs     = s_awvalid & s_awready;
   assign w_last_hs = s_wvalid & s_wready & s_wlast;
   assign b_hs      = s_bvalid & s_bready;
   // AW and W complete independently; either flag or a same-cycle handshake counts.
   assign aw_fin    = aw_done | aw_hs;
   assign w_fin     = w_done | w_last_hs;

   assign rd_busy = (r_state != R_IDLE);
   assign wr_busy = (w_state != W_IDLE);
   assign rd_gnt  = rd_gnt_q;
   assign wr_gnt  = wr_gnt_q;

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (|m_arvalid) r_next = R_ADDR;
         R_ADDR:  if (ar_hs) r_next = R_DATA;
         R_DATA:  if (r_hs && s_rlast) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (|m_awvalid) w_next = W_XFER;
         W_XFER:  if (aw_fin && w_fin) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= R_IDLE;
         rd_ptr   <= '0;
         rd_gnt_q <= '0;
         hold_q   <= '0;
      end else begin
         r_state <= r_next;
         if (r_state == R_IDLE && |m_arvalid)
            rd_gnt_q <= rr_pick(rd_ptr, m_arvalid);
         if (r_hs)
            hold_q[rd_gnt_q*DATA_W +: DATA_W] <= s_rdata;
         if (r_hs && s_rlast)
            rd_ptr <= wrap_inc(rd_gnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state  <= W_IDLE;
         wr_ptr   <= '0;
         wr_gnt_q <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         w_state <= w_next;
         if (w_state == W_IDLE && |m_awvalid)
            wr_gnt_q <= rr_pick(wr_ptr, m_awvalid);
         aw_done <= (w_state == W_XFER) && (w_next == W_XFER) && aw_fin;
         w_done  <= (w_state == W_XFER) && (w_next == W_XFER) && w_fin;
         if (b_hs)
            wr_ptr <= wrap_inc(wr_gnt_q);
      end
   end

   always_comb begin
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_arsize  = '0;
      s_rready  = 1'b0;
      m_arready = '0;
      m_rvalid  = '0;
      m_rresp   = '0;
      m_rlast   = '0;
      m_rdata   = hold_q;
      if (r_state == R_ADDR) begin
         s_arvalid           = m_arvalid[rd_gnt_q];
         s_araddr            = m_araddr[rd_gnt_q*ADDR_W +: ADDR_W];
         s_arlen             = m_arlen[rd_gnt_q*8 +: 8];
         s_arsize            = m_arsize[rd_gnt_q*3 +: 3];
         m_arready[rd_gnt_q] = s_arready;
      end
      if (r_state == R_DATA) begin
         s_rready                 = m_rready[rd_gnt_q];
         m_rvalid[rd_gnt_q]       = s_rvalid;
         m_rlast[rd_gnt_q]        = s_rvalid & s_rlast;
         m_rresp[rd_gnt_q*2 +: 2] = s_rresp;
         // Live beat bypasses the hold register.
         if (s_rvalid)
            m_rdata[rd_gnt_q*DATA_W +: DATA_W] = s_rdata;
      end
   end

   always_comb begin
      s_awvalid = 1'b0;
      s_awaddr  = '0;
      s_awlen   = '0;
      s_awsize  = '0;
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wlast   = 1'b0;
      s_bready  = 1'b0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = '0;
      if (w_state == W_XFER) begin
         s_awvalid           = m_awvalid[wr_gnt_q] & ~aw_done;
         s_awaddr            = m_awaddr[wr_gnt_q*ADDR_W +: ADDR_W];
         s_awlen             = m_awlen[wr_gnt_q*8 +: 8];
         s_awsize            = m_awsize[wr_gnt_q*3 +: 3];
         m_awready[wr_gnt_q] = s_awready & ~aw_done;
         s_wvalid            = m_wvalid[wr_gnt_q] & ~w_done;
         s_wdata             = m_wdata[wr_gnt_q*DATA_W +: DATA_W];
         s_wstrb             = m_wstrb[wr_gnt_q*STRB_W +: STRB_W];
         s_wlast             = m_wlast[wr_gnt_q];
         m_wready[wr_gnt_q]  = s_wready & ~w_done;
      end
      if (w_state == W_RESP) begin
         s_bready                 = m_bready[wr_gnt_q];
         m_bvalid[wr_gnt_q]       = s_bvalid;
         m_bresp[wr_gnt_q*2 +: 2] = s_bresp;
      end
   end

endmodule
